hilo_muldiv_ctrl: RTL and testbench

- Execute-stage controller that owns the architectural HI/LO register pair.
- Sequences MULT/MULTU (2-cycle), DIV/DIVU (iterative radix-2 restoring, 32 iterations) and MTHI/MTLO.
- Raises a pipeline stall while busy and commits results to HI/LO only when the instruction leaves EX unflushed.
- The ALU reads the `hilo` output for MFHI/MFLO.

---
 rtl/hilo_muldiv_ctrl.sv | 157 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner for the execute stage: multiply, iterative divide, MTHI/MTLO.
// Results commit to HI/LO only when the instruction leaves EX unflushed.
module hilo_muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                flush,
    input  logic                pipe_adv,
    output logic                stall,
    output logic                busy,
    output logic [2*DATA_W-1:0] hilo
);

    localparam int W = DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_d;

    logic [2*W-1:0] res;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   rem;
    logic [4:0]     cnt;
    logic           mul_signed;
    logic           sgn_a;
    logic           sgn_b;

    logic is_mul, is_div, is_mt, b_zero;
    logic [2*W-1:0] prod;
    logic [W:0]     rem_sh, diff;
    logic [W-1:0]   rem_n, quo_n, q_fix, r_fix;

    assign is_mul = (op == 3'd1) || (op == 3'd2);
    assign is_div = (op == 3'd3) || (op == 3'd4);
    assign is_mt  = (op == 3'd5) || (op == 3'd6);
    assign b_zero = (b == '0);

    assign stall = !rst && !flush &&
                   ((state == S_IDLE && start && (is_mul || is_div)) ||
                    state == S_MUL || state == S_DIV);
    assign busy  = !rst && (state != S_IDLE);

    // Multiplier and one restoring divide step; op_a doubles as the quotient.
    always_comb begin
        prod   = {{W{mul_signed & op_a[W-1]}}, op_a} *
                 {{W{mul_signed & op_b[W-1]}}, op_b};
        rem_sh = {rem, op_a[W-1]};
        diff   = rem_sh - {1'b0, op_b};
        if (diff[W]) begin
            rem_n = rem_sh[W-1:0];
            quo_n = {op_a[W-2:0], 1'b0};
        end else begin
            rem_n = diff[W-1:0];
            quo_n = {op_a[W-2:0], 1'b1};
        end
        q_fix = (sgn_a ^ sgn_b) ? -quo_n : quo_n;
        r_fix = sgn_a ? -rem_n : rem_n;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && is_mul)
                        state_d = S_MUL;
                    else if (start && is_div)
                        state_d = b_zero ? S_DONE : S_DIV;
                end
                S_MUL:  state_d = S_DONE;
                S_DIV:  if (cnt == 5'd31) state_d = S_DONE;
                S_DONE: if (pipe_adv) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, result and HI/LO commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo       <= '0;
            res        <= '0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rem        <= '0;
            mul_signed <= 1'b0;
            sgn_a      <= 1'b0;
            sgn_b      <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            is_mul: begin
                                op_a       <= a;
                                op_b       <= b;
                                mul_signed <= (op == 3'd1);
                            end
                            is_div: begin
                                if (b_zero) begin
                                    res <= hilo;
                                end else begin
                                    sgn_a <= (op == 3'd3) & a[W-1];
                                    sgn_b <= (op == 3'd3) & b[W-1];
                                    op_a  <= ((op == 3'd3) && a[W-1]) ? -a : a;
                                    op_b  <= ((op == 3'd3) && b[W-1]) ? -b : b;
                                    rem   <= '0;
                                    cnt   <= '0;
                                end
                            end
                            is_mt: begin
                                if (pipe_adv) begin
                                    if (op == 3'd5) hilo[2*W-1:W] <= a;
                                    else            hilo[W-1:0]   <= a;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: res <= prod;
                S_DIV: begin
                    op_a <= quo_n;
                    rem  <= rem_n;
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd31) res <= {r_fix, q_fix};
                end
                S_DONE: if (pipe_adv) hilo <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl.
// Inputs change and outputs are sampled around the falling edge.
module tb_hilo_muldiv_ctrl;

    logic        clk = 0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        pipe_adv;
    logic        stall;
    logic        busy;
    logic [63:0] hilo;

    int checks = 0;
    int fails  = 0;
    int stalls;
    bit to;

    hilo_muldiv_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .pipe_adv(pipe_adv), .stall(stall),
        .busy(busy), .hilo(hilo)
    );

    always #5 clk = ~clk;

    // Issue an op and wait until stall drops (DONE); counts stalled cycles.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        start = 1; op = o; a = x; b = y; pipe_adv = 0; flush = 0;
        stalls = 0; to = 1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                to = 0;
                break;
            end
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic commit();
        pipe_adv = 1;
        @(negedge clk);
        pipe_adv = 0; start = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; op = 3'd1; a = 0; b = 0; flush = 0; pipe_adv = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL reset_stall got=%b exp=0", stall);
        end
        start = 0;
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (hilo !== 64'd0) begin
            fails++; $display("FAIL reset_hilo got=%h exp=0", hilo);
        end
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL reset_busy got=%b%b exp=00", busy, stall);
        end
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op(3'd1, 32'hFFFFFFFD, 32'd5);
        checks++;
        if (to || stalls != 2 || busy !== 1'b1) begin
            fails++; $display("FAIL mult_stall got=%0d to=%0d busy=%b exp=2", stalls, to, busy);
        end
        commit();
        checks++;
        if (hilo !== 64'hFFFFFFFF_FFFFFFF1) begin
            fails++; $display("FAIL mult_hilo got=%h exp=ffffffff_fffffff1", hilo);
        end
        run_op(3'd2, 32'hFFFFFFFD, 32'd5);
        commit();
        checks++;
        if (to || stalls != 2 || hilo !== 64'h00000004_FFFFFFF1) begin
            fails++; $display("FAIL multu_hilo got=%h st=%0d exp=00000004_fffffff1 st=2", hilo, stalls);
        end
    endtask

    task automatic test_div();
        run_op(3'd3, -32'sd7, 32'd2);
        checks++;
        if (to || stalls != 33) begin
            fails++; $display("FAIL div_stall got=%0d to=%0d exp=33", stalls, to);
        end
        commit();
        checks++;
        if (hilo !== 64'hFFFFFFFF_FFFFFFFD) begin
            fails++; $display("FAIL div_neg got=%h exp=ffffffff_fffffffd", hilo);
        end
        run_op(3'd4, 32'd100, 32'd7);
        commit();
        checks++;
        if (hilo !== 64'h00000002_0000000E) begin
            fails++; $display("FAIL divu got=%h exp=00000002_0000000e", hilo);
        end
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        commit();
        checks++;
        if (hilo !== 64'h00000000_80000000) begin
            fails++; $display("FAIL div_ovf got=%h exp=00000000_80000000", hilo);
        end
    endtask

    task automatic test_mt();
        start = 1; op = 3'd5; a = 32'hAAAA0000; pipe_adv = 1; flush = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL mthi_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        op = 3'd6; a = 32'h5555FFFF;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL mtlo_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        start = 0; pipe_adv = 0;
        #1;
        checks++;
        if (hilo !== 64'hAAAA0000_5555FFFF || busy !== 1'b0) begin
            fails++; $display("FAIL mt_hilo got=%h busy=%b exp=aaaa0000_5555ffff", hilo, busy);
        end
        start = 1; op = 3'd5; a = 32'h12345678; pipe_adv = 0;
        @(negedge clk);
        start = 0;
        #1;
        checks++;
        if (hilo !== 64'hAAAA0000_5555FFFF) begin
            fails++; $display("FAIL mt_noadv got=%h exp=aaaa0000_5555ffff", hilo);
        end
    endtask

    task automatic test_div_zero();
        start = 1; op = 3'd5; a = 32'h11111111; pipe_adv = 1; flush = 0;
        @(negedge clk);
        op = 3'd6; a = 32'h22222222;
        @(negedge clk);
        start = 0; pipe_adv = 0;
        run_op(3'd4, 32'd55, 32'd0);
        checks++;
        if (to || stalls != 1) begin
            fails++; $display("FAIL divz_stall got=%0d to=%0d exp=1", stalls, to);
        end
        commit();
        checks++;
        if (hilo !== 64'h11111111_22222222) begin
            fails++; $display("FAIL divz_hilo got=%h exp=11111111_22222222", hilo);
        end
    endtask

    task automatic test_flush();
        start = 1; op = 3'd3; a = 32'd1000; b = 32'd3; flush = 0; pipe_adv = 0;
        repeat (11) @(negedge clk);
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL flush_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        flush = 0; start = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || hilo !== 64'h11111111_22222222) begin
            fails++; $display("FAIL flush_idle busy=%b stall=%b hilo=%h exp=0 0 11111111_22222222", busy, stall, hilo);
        end
        @(negedge clk);
        run_op(3'd1, 32'd6, 32'd7);
        commit();
        checks++;
        if (to || stalls != 2 || hilo !== 64'd42) begin
            fails++; $display("FAIL flush_next got=%h st=%0d exp=2a st=2", hilo, stalls);
        end
        start = 1; op = 3'd3; a = 32'd1000; b = 32'd3;
        repeat (11) @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL rst_stall got=%b exp=0", stall);
        end
        @(negedge clk);
        rst = 0; start = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || hilo !== 64'd0) begin
            fails++; $display("FAIL rst_abort busy=%b hilo=%h exp=0 0", busy, hilo);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        run_op(3'd1, 32'd2, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (stall !== 1'b0 || busy !== 1'b1 || hilo !== 64'd0) begin
                fails++; $display("FAIL hold_%0d stall=%b busy=%b hilo=%h exp=0 1 0", i, stall, busy, hilo);
            end
        end
        commit();
        checks++;
        if (hilo !== 64'd6 || busy !== 1'b0) begin
            fails++; $display("FAIL hold_commit hilo=%h busy=%b exp=6 0", hilo, busy);
        end
        run_op(3'd1, 32'd4, 32'd5);
        flush = 1; pipe_adv = 1;
        @(negedge clk);
        flush = 0; pipe_adv = 0; start = 0;
        #1;
        checks++;
        if (hilo !== 64'd6 || busy !== 1'b0) begin
            fails++; $display("FAIL hold_flush hilo=%h busy=%b exp=6 0", hilo, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_op(3'd2, 32'd9, 32'd9);
        commit();
        run_op(3'd4, 32'd81, 32'd4);
        checks++;
        if (to || stalls != 33) begin
            fails++; $display("FAIL b2b_stall got=%0d to=%0d exp=33", stalls, to);
        end
        commit();
        checks++;
        if (hilo !== 64'h00000001_00000014) begin
            fails++; $display("FAIL b2b_hilo got=%h exp=00000001_00000014", hilo);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_div_zero();
        test_flush();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
